// File: rtl/vga_pkg.sv
// Shared timing constants, pattern-mode encodings and frame-size helper for the VGA back end.
package vga_pkg;

    localparam int unsigned VGA_CLK_DIV  = 4;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_BORDER = 2'd1;
    localparam logic [1:0] MODE_BARS   = 2'd2;
    localparam logic [1:0] MODE_CHECK  = 2'd3;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider plus horizontal/vertical raster counters and region decode.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        tick,
    output logic [15:0] h_cnt,
    output logic [15:0] v_cnt,
    output logic        active,
    output logic        hsync_n,
    output logic        vsync_n
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [15:0]      r_h;
    logic [15:0]      r_v;

    // With CLK_DIV = 1 the divider sits at 0 and the tick is permanently high.
    assign tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (tick) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? 16'd0 : r_v + 16'd1;
            end else begin
                r_h <= r_h + 16'd1;
            end
        end
    end

    assign h_cnt   = r_h;
    assign v_cnt   = r_v;
    assign active  = (r_h < 16'(H_ACTIVE)) && (r_v < 16'(V_ACTIVE));
    assign hsync_n = !((r_h >= HS_START) && (r_h < HS_END));
    assign vsync_n = !((r_v >= VS_START) && (r_v < VS_END));

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA back end: raster timing, four test patterns and a single aligned output register stage.
module vga_pattern_engine
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned BORDER   = 8,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               video_on,
    output logic [15:0]        pix_x,
    output logic [15:0]        pix_y,
    output logic               pixel_tick,
    output logic               frame_start
);

    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic        SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;
    localparam logic [COLOR_W-1:0] C_MAX = '1;

    logic        w_tick;
    logic [15:0] w_h;
    logic [15:0] w_v;
    logic        w_active;
    logic        w_hs_n;
    logic        w_vs_n;

    vga_timing_counter #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .tick    (w_tick),
        .h_cnt   (w_h),
        .v_cnt   (w_v),
        .active  (w_active),
        .hsync_n (w_hs_n),
        .vsync_n (w_vs_n)
    );

    logic [1:0]  r_mode;
    logic [1:0]  w_mode;
    logic        w_first;
    logic [15:0] w_bar;
    logic [2:0]  w_bar_idx;
    logic        w_edge;
    logic [COLOR_W-1:0] w_r, w_g, w_b;

    // Pixel (0,0) already uses the mode being latched on that same tick.
    assign w_first   = (w_h == 16'd0) && (w_v == 16'd0);
    assign w_mode    = w_first ? mode : r_mode;
    assign w_bar     = w_h / 16'(BAR_W);
    assign w_bar_idx = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
    assign w_edge    = (w_h < 16'(BORDER)) || (w_h >= 16'(H_ACTIVE - BORDER)) ||
                       (w_v < 16'(BORDER)) || (w_v >= 16'(V_ACTIVE - BORDER));

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_active) begin
            unique case (w_mode)
                MODE_SOLID: begin
                    w_r = C_MAX;
                    w_g = C_MAX;
                    w_b = C_MAX;
                end
                MODE_BORDER: begin
                    if (w_edge) begin
                        w_r = C_MAX;
                        w_g = C_MAX;
                        w_b = C_MAX;
                    end
                end
                MODE_BARS: begin
                    w_r = w_bar_idx[2] ? C_MAX : '0;
                    w_g = w_bar_idx[1] ? C_MAX : '0;
                    w_b = w_bar_idx[0] ? C_MAX : '0;
                end
                MODE_CHECK: begin
                    if (w_h[CHK_LOG2] ^ w_v[CHK_LOG2]) begin
                        w_r = C_MAX;
                        w_g = C_MAX;
                        w_b = C_MAX;
                    end
                end
            endcase
        end
    end

    logic               r_hsync, r_vsync, r_video_on, r_pixel_tick, r_frame_start;
    logic [COLOR_W-1:0] r_red, r_green, r_blue;
    logic [15:0]        r_pix_x, r_pix_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode        <= MODE_SOLID;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_video_on    <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pixel_tick  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_tick  <= w_tick;
            r_frame_start <= w_tick && w_first;
            if (w_tick) begin
                if (w_first) begin
                    r_mode <= mode;
                end
                r_hsync    <= w_hs_n ? SYNC_IDLE : ~SYNC_IDLE;
                r_vsync    <= w_vs_n ? SYNC_IDLE : ~SYNC_IDLE;
                r_red      <= w_r;
                r_green    <= w_g;
                r_blue     <= w_b;
                r_video_on <= w_active;
                r_pix_x    <= w_h;
                r_pix_y    <= w_v;
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign video_on    = r_video_on;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pixel_tick  = r_pixel_tick;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Directed bench: default 640x480 timing, a reduced 128x64 raster for patterns, and a tiny CLK_DIV=1 raster.
module tb_vga_pattern_engine;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Default instance
    logic d_reset = 1'b1;
    logic [1:0] d_mode = 2'd0;
    logic d_hsync, d_vsync, d_video_on, d_pixel_tick, d_frame_start;
    logic [3:0] d_red, d_green, d_blue;
    logic [15:0] d_pix_x, d_pix_y;

    vga_pattern_engine u_dflt (
        .clk (clk), .reset (d_reset), .mode (d_mode),
        .hsync (d_hsync), .vsync (d_vsync), .red (d_red), .green (d_green), .blue (d_blue),
        .video_on (d_video_on), .pix_x (d_pix_x), .pix_y (d_pix_y),
        .pixel_tick (d_pixel_tick), .frame_start (d_frame_start)
    );

    // Reduced raster: 128x64 active, H_TOTAL=144, V_TOTAL=72, one clk per pixel
    logic m_reset = 1'b1;
    logic [1:0] m_mode = 2'd2;
    logic m_hsync, m_vsync, m_video_on, m_pixel_tick, m_frame_start;
    logic [3:0] m_red, m_green, m_blue;
    logic [15:0] m_pix_x, m_pix_y;

    vga_pattern_engine #(
        .CLK_DIV (1), .H_ACTIVE (128), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (64), .V_FP (2), .V_SYNC (2), .V_BP (4)
    ) u_mid (
        .clk (clk), .reset (m_reset), .mode (m_mode),
        .hsync (m_hsync), .vsync (m_vsync), .red (m_red), .green (m_green), .blue (m_blue),
        .video_on (m_video_on), .pix_x (m_pix_x), .pix_y (m_pix_y),
        .pixel_tick (m_pixel_tick), .frame_start (m_frame_start)
    );

    // Tiny raster with active-high sync
    logic s_reset = 1'b1;
    logic [1:0] s_mode = 2'd0;
    logic s_hsync, s_vsync, s_video_on, s_pixel_tick, s_frame_start;
    logic [3:0] s_red, s_green, s_blue;
    logic [15:0] s_pix_x, s_pix_y;

    vga_pattern_engine #(
        .CLK_DIV (1), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1), .BORDER (1)
    ) u_small (
        .clk (clk), .reset (s_reset), .mode (s_mode),
        .hsync (s_hsync), .vsync (s_vsync), .red (s_red), .green (s_green), .blue (s_blue),
        .video_on (s_video_on), .pix_x (s_pix_x), .pix_y (s_pix_y),
        .pixel_tick (s_pixel_tick), .frame_start (s_frame_start)
    );

    task automatic d_wait_pix(input int x, input int y);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 20000) begin
            @(negedge clk);
            n++;
            hit = d_pixel_tick && d_pix_x == 16'(x) && d_pix_y == 16'(y);
        end
        if (!hit) check("d_wait_timeout", 0, 1);
    endtask

    task automatic m_wait_pix(input int x, input int y);
        int n = 0;
        bit hit = 0;
        while (!hit && n < 25000) begin
            @(negedge clk);
            n++;
            hit = m_pixel_tick && m_pix_x == 16'(x) && m_pix_y == 16'(y);
        end
        if (!hit) check("m_wait_timeout", 0, 1);
    endtask

    task automatic m_wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_frame_start && n < 25000);
        if (!m_frame_start) check("m_frame_timeout", 0, 1);
    endtask

    task automatic run_dflt();
        int n, hs_first, hs_low, act, nonwhite, ticks;
        repeat (3) @(negedge clk);
        check("d_rst_hsync", d_hsync, 1);
        check("d_rst_vsync", d_vsync, 1);
        check("d_rst_rgb", {d_red, d_green, d_blue}, 0);
        check("d_rst_video_on", d_video_on, 0);
        check("d_rst_pix", {d_pix_x, d_pix_y}, 0);
        check("d_rst_pulses", {d_pixel_tick, d_frame_start}, 0);
        d_reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_frame_start && n < 100);
        check("d_first_fs_latency", n, 4);
        check("d_first_pix", {d_pix_x, d_pix_y}, 0);
        check("d_first_rgb", {d_red, d_green, d_blue}, 12'hFFF);
        // Walk line 0 (800 pixels * 4 clks), starting at the (0,0) pixel
        hs_first = -1;
        hs_low = 0;
        act = d_video_on ? 1 : 0;
        nonwhite = 0;
        ticks = 1;
        for (int k = 1; k < 3200; k++) begin
            @(negedge clk);
            if (!d_hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_low++;
            end
            if (d_pixel_tick) begin
                ticks++;
                if (d_video_on) begin
                    act++;
                    if ({d_red, d_green, d_blue} != 12'hFFF) nonwhite++;
                end
            end
        end
        check("d_hsync_start", hs_first, 2624);
        check("d_hsync_len", hs_low, 384);
        check("d_line_ticks", ticks, 800);
        check("d_line_active", act, 640);
        check("d_line_nonwhite", nonwhite, 0);
        d_wait_pix(400, 1);
        check("d_pre_rst_rgb", {d_red, d_green, d_blue}, 12'hFFF);
        d_reset = 1'b1;
        #1;
        check("d_async_hv", {d_hsync, d_vsync}, 2'b11);
        check("d_async_rgb", {d_red, d_green, d_blue}, 0);
        check("d_async_video_fs", {d_video_on, d_frame_start}, 0);
        check("d_async_pix", {d_pix_x, d_pix_y}, 0);
        @(negedge clk);
        d_reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_frame_start && n < 100);
        check("d_rerst_fs_latency", n, 4);
        check("d_rerst_pix", {d_pix_x, d_pix_y}, 0);
    endtask

    task automatic run_mid();
        int n;
        int bx[10] = '{0, 15, 16, 32, 48, 64, 80, 96, 112, 127};
        logic [11:0] bc[10] = '{12'h000, 12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                12'hF00, 12'hF0F, 12'hFF0, 12'hFFF, 12'hFFF};
        repeat (3) @(negedge clk);
        m_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            m_wait_pix(bx[i], 0);
            check($sformatf("m_bar_x%0d", bx[i]), {m_red, m_green, m_blue}, bc[i]);
        end
        m_mode = 2'd1;
        m_wait_frame();
        m_wait_pix(7, 20);
        check("m_border_7_20", {m_red, m_green, m_blue}, 12'hFFF);
        m_wait_pix(8, 20);
        check("m_border_8_20", {m_red, m_green, m_blue}, 12'h000);
        m_wait_pix(120, 20);
        check("m_border_120_20", {m_red, m_green, m_blue}, 12'hFFF);
        m_wait_pix(20, 55);
        check("m_border_20_55", {m_red, m_green, m_blue}, 12'h000);
        m_wait_pix(20, 56);
        check("m_border_20_56", {m_red, m_green, m_blue}, 12'hFFF);
        m_mode = 2'd0;
        m_wait_frame();
        check("m_solid_origin", {m_red, m_green, m_blue}, 12'hFFF);
        m_wait_pix(64, 32);
        m_mode = 2'd3;
        m_wait_pix(32, 50);
        check("m_switch_held", {m_red, m_green, m_blue}, 12'hFFF);
        n = 0;
        while (m_vsync && n < 25000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!m_vsync && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check("m_vsync_len", n, 288);
        m_wait_frame();
        check("m_chk_origin", {m_red, m_green, m_blue}, 12'h000);
        m_wait_pix(32, 0);
        check("m_chk_32_0", {m_red, m_green, m_blue}, 12'hFFF);
        m_wait_pix(0, 32);
        check("m_chk_0_32", {m_red, m_green, m_blue}, 12'hFFF);
        m_wait_pix(32, 32);
        check("m_chk_32_32", {m_red, m_green, m_blue}, 12'h000);
    endtask

    task automatic run_small();
        int n, k, ticks, hs_first, hs_high, vs_first, vs_high;
        repeat (3) @(negedge clk);
        check("s_rst_sync", {s_hsync, s_vsync}, 2'b00);
        s_reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_frame_start && n < 200);
        check("s_first_fs_latency", n, 1);
        k = 0;
        ticks = 0;
        hs_first = -1;
        hs_high = 0;
        vs_first = -1;
        vs_high = 0;
        do begin
            @(negedge clk);
            k++;
            if (s_pixel_tick) ticks++;
            if (s_hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_high++;
            end
            if (s_vsync) begin
                if (vs_first < 0) vs_first = k;
                vs_high++;
            end
        end while (!s_frame_start && k < 300);
        check("s_frame_len", k, 98);
        check("s_ticks", ticks, 98);
        check("s_hsync_start", hs_first, 10);
        check("s_hsync_high", hs_high, 14);
        check("s_vsync_start", vs_first, 70);
        check("s_vsync_high", vs_high, 14);
    endtask

    initial begin
        fork
            run_dflt();
            run_mid();
            run_small();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
